// File: rtl/la_sample_uploader_if.sv
// Read port of the standard-mode sample FIFO.
// master = uploader (reader), slave = FIFO.
interface la_sample_uploader_if;
  logic       fifo_empty;
  logic [7:0] fifo_rdata;
  logic       fifo_ren;

  modport master (
    input  fifo_empty,
    input  fifo_rdata,
    output fifo_ren
  );

  modport slave (
    output fifo_empty,
    output fifo_rdata,
    input  fifo_ren
  );
endinterface

// File: rtl/la_sample_uploader.sv
// Drains capture FIFO samples and streams them as 8N1 UART bursts,
// each burst led by a sync byte.
module la_sample_uploader #(
  parameter int         CLK_DIV   = 434,
  parameter int         BURST_LEN = 16,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  la_sample_uploader_if.master        fifo,
  output logic                        uart_tx,
  output logic                        busy,
  output logic [15:0]                 burst_cnt
);

  typedef enum logic [2:0] {
    IDLE, SYNC, FETCH, LATCH, SHIFT, WAITF
  } state_t;

  localparam logic [15:0] BAUD_MAX = 16'(CLK_DIV - 1);
  localparam logic [7:0]  SAMP_MAX = 8'(BURST_LEN);

  state_t      state;
  state_t      state_n;
  logic [15:0] baud;
  logic [3:0]  bitn;
  logic [7:0]  sreg;
  logic [7:0]  scnt;
  logic        bit_end;
  logic        frame_end;
  logic        done;

  assign bit_end   = (baud == BAUD_MAX);
  assign frame_end = (state == SHIFT) && bit_end && (bitn == 4'd9);
  assign done      = (scnt == SAMP_MAX);

  assign busy          = (state != IDLE);
  assign fifo.fifo_ren = (state == FETCH) && !fifo.fifo_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (enable && !fifo.fifo_empty) state_n = SYNC;
      SYNC:  state_n = SHIFT;
      FETCH: state_n = LATCH;
      LATCH: state_n = SHIFT;
      SHIFT: begin
        if (frame_end) begin
          if (done)                  state_n = IDLE;
          else if (!enable)          state_n = IDLE;
          else if (!fifo.fifo_empty) state_n = FETCH;
          else                       state_n = WAITF;
        end
      end
      WAITF: begin
        if (!enable)               state_n = IDLE;
        else if (!fifo.fifo_empty) state_n = FETCH;
      end
      default: state_n = IDLE;
    endcase
  end

  // Start bit is driven on the edge that enters SHIFT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      uart_tx   <= 1'b1;
      sreg      <= '0;
      baud      <= '0;
      bitn      <= '0;
      scnt      <= '0;
      burst_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          uart_tx <= 1'b1;
          scnt    <= '0;
        end
        SYNC: begin
          sreg    <= SYNC_BYTE;
          uart_tx <= 1'b0;
          baud    <= '0;
          bitn    <= '0;
        end
        LATCH: begin
          sreg    <= fifo.fifo_rdata;
          scnt    <= scnt + 8'd1;
          uart_tx <= 1'b0;
          baud    <= '0;
          bitn    <= '0;
        end
        SHIFT: begin
          if (bit_end) begin
            baud <= '0;
            if (bitn == 4'd9) begin
              uart_tx <= 1'b1;
              if (done) burst_cnt <= burst_cnt + 16'd1;
            end else begin
              bitn    <= bitn + 4'd1;
              uart_tx <= (bitn == 4'd8) ? 1'b1
                                        : sreg[bitn[2:0]];
            end
          end else begin
            baud <= baud + 16'd1;
          end
        end
        default: uart_tx <= 1'b1;
      endcase
    end
  end

endmodule

// File: doc/la_sample_uploader.md
Name: la_sample_uploader

Overview:
- Read side of the logic-analysis capture FIFO: drains 8-bit samples written by the capture block and streams them to the host over a UART TX line.
- Samples go out in bursts. Each burst is one sync byte followed by up to BURST_LEN sample bytes.
- Frame format: 8N1, LSB first, fixed baud divisor. Sits between the sample FIFO and the board UART pin.

Parameters:
- CLK_DIV, 434, clk cycles per UART bit (50 MHz / 115200); legal range 2..65535.
- BURST_LEN, 16, sample bytes per burst after the sync byte; legal range 1..255.
- SYNC_BYTE, 8'hA5, burst header byte.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- enable  in  1  upload enable, level-sensitive.
- fifo_empty  in  1  sample FIFO empty flag.
- fifo_rdata  in  8  FIFO read data, valid exactly 1 cycle after fifo_ren (standard-mode FIFO).
- fifo_ren  out  1  FIFO read strobe, single-cycle pulse.
- uart_tx  out  1  serial output, idle high.
- busy  out  1  high whenever state != IDLE.
- burst_cnt  out  16  completed bursts since reset, wraps at 65535->0.

Behaviour:
- Reset values: fifo_ren=0, uart_tx=1, busy=0, burst_cnt=0, state=IDLE, all counters 0.
- FSM states: IDLE, SYNC, FETCH, LATCH, SHIFT, WAITF.
- IDLE: if enable && !fifo_empty -> SYNC (clear sample count).
- SYNC: load SYNC_BYTE into the shift register; -> SHIFT.
- FETCH: assert fifo_ren for exactly 1 cycle; -> LATCH.
- LATCH: capture fifo_rdata into the shift register; increment sample count; -> SHIFT.
- SHIFT: transmit the 10-bit frame (start 0, d[0]..d[7], stop 1). Each bit is held exactly CLK_DIV cycles; frame = 10*CLK_DIV cycles. On the last cycle of the stop bit, evaluate in priority order:
  - (a) sample count == BURST_LEN: burst_cnt += 1 -> IDLE.
  - (b) !enable: -> IDLE; burst truncated, burst_cnt unchanged.
  - (c) !fifo_empty: -> FETCH.
  - (d) otherwise: -> WAITF.
- WAITF: uart_tx held 1. If !enable -> IDLE (truncated); else if !fifo_empty -> FETCH.
- A truncated burst never restarts mid-burst. The next burst always begins with a fresh SYNC.
- Latency:
  - IDLE->start bit of sync: uart_tx goes low 2 cycles after the first cycle enable && !fifo_empty is sampled high.
  - Stop bit end -> next start bit: FETCH + LATCH adds exactly 2 idle-high cycles between consecutive sample frames. Sync->first sample also has the 2-cycle gap.
- fifo_ren is never asserted while fifo_empty=1 in the same cycle, and never asserted in any state other than FETCH.
- No read-ahead: at most one sample is in flight, so FIFO occupancy changes only by FETCH reads.
- uart_tx is driven from a register (glitch-free). It is 1 in IDLE, WAITF, FETCH and LATCH.
- Bit counter 0..9, baud counter 0..CLK_DIV-1, sample counter 8 bits.
- enable deassertion during a frame never cuts the frame short.
- Asynchronous rst at any point: outputs return to reset values immediately; a partial frame on uart_tx is abandoned (line forced high).
- fifo_rdata is ignored outside LATCH.

Test Plan:
- CLK_DIV=4, BURST_LEN=4, FIFO preloaded {0x01,0x02,0x03,0x04}, enable=1 -> uart_tx carries frames A5,01,02,03,04, each 40 cycles, 2-cycle high gaps; exactly 4 fifo_ren pulses; burst_cnt=1; busy falls after the last stop bit.
- Same config, FIFO holds 2 samples, 3rd sample written 100 cycles after the 2nd frame ends -> FSM sits in WAITF with uart_tx=1; the 3rd frame starts 3 cycles after fifo_empty drops; burst_cnt increments only after the 4th sample.
- enable dropped mid-way through the sample-1 frame -> that frame completes intact, FSM returns to IDLE, burst_cnt unchanged. Re-enable -> the next transmission starts with 0xA5.
- Frame integrity: sample 0x80, CLK_DIV=4 -> bit sequence 0,0,0,0,0,0,0,0,1,1, each held 4 cycles.
- rst pulsed mid data bit -> uart_tx=1, fifo_ren=0, busy=0 in the same cycle; after release, FIFO not empty and enable=1 -> a fresh burst starts with the sync byte.
- Wrap: force burst_cnt to 16'hFFFF, complete 1 burst -> burst_cnt=0.
